// File: rtl/baccarat_pkg.sv
// Shared card/rank types and helpers for the baccarat hand datapath.
package baccarat_pkg;

  typedef logic [3:0] rank_t;

  localparam rank_t RANK_EMPTY = 4'd0;
  localparam rank_t RANK_MAX   = 4'd13;
  localparam rank_t FACE_MIN   = 4'd10;

  localparam logic [1:0] LIGHTS_NONE   = 2'b00;
  localparam logic [1:0] LIGHTS_DEALER = 2'b01;
  localparam logic [1:0] LIGHTS_PLAYER = 2'b10;
  localparam logic [1:0] LIGHTS_TIE    = 2'b11;

  // Tens and face cards count as zero, as does an empty slot.
  function automatic rank_t card_value(input rank_t r);
    if (r == RANK_EMPTY || r >= FACE_MIN) return 4'd0;
    return r;
  endfunction

  function automatic logic rank_valid(input rank_t r);
    return (r != RANK_EMPTY) && (r <= RANK_MAX);
  endfunction

endpackage

// File: rtl/score_hand.sv
// Combinational three-card baccarat score (sum of card values mod 10).
module score_hand
  import baccarat_pkg::*;
(
  input  rank_t       card1_i,
  input  rank_t       card2_i,
  input  rank_t       card3_i,
  output logic [3:0]  score_o
);

  logic [4:0] sum;

  // Max sum is 27, so at most two tens need to come off.
  always_comb begin
    sum = {1'b0, card_value(card1_i)} + {1'b0, card_value(card2_i)} + {1'b0, card_value(card3_i)};
    if (sum >= 5'd20)      score_o = 4'(sum - 5'd20);
    else if (sum >= 5'd10) score_o = 4'(sum - 5'd10);
    else                   score_o = sum[3:0];
  end

endmodule

// File: rtl/card_datapath.sv
// Card capture, hand scoring and round-outcome tally feeding the round controller.
module card_datapath
  import baccarat_pkg::*;
#(
  parameter int TALLY_W = 8
) (
  input  logic               slow_clock,
  input  logic               resetb,
  input  rank_t              new_card,
  input  logic               load_pcard1,
  input  logic               load_pcard2,
  input  logic               load_pcard3,
  input  logic               load_dcard1,
  input  logic               load_dcard2,
  input  logic               load_dcard3,
  input  logic               player_win_light,
  input  logic               dealer_win_light,
  output rank_t              pcard1,
  output rank_t              pcard2,
  output rank_t              pcard3,
  output rank_t              dcard1,
  output rank_t              dcard2,
  output rank_t              dcard3,
  output rank_t              pcard3_out,
  output logic [3:0]         pscore,
  output logic [3:0]         dscore,
  output logic [TALLY_W-1:0] p_wins,
  output logic [TALLY_W-1:0] d_wins,
  output logic [TALLY_W-1:0] ties,
  output logic [TALLY_W-1:0] rounds,
  output logic               card_err
);

  typedef logic [TALLY_W-1:0] tally_t;

  function automatic tally_t sat_inc(input tally_t c);
    return (c == '1) ? c : c + TALLY_W'(1);
  endfunction

  logic [2:0][3:0] pslot_q, pslot_d, dslot_q, dslot_d;
  logic [2:0]      p_ld, d_ld;
  logic            err_q, err_d;
  logic [1:0]      lights, lights_prev_q;
  logic            card_ok, any_load, round_evt;
  tally_t          p_wins_q, p_wins_d, d_wins_q, d_wins_d;
  tally_t          ties_q, ties_d, rounds_q, rounds_d;

  assign p_ld   = {load_pcard3, load_pcard2, load_pcard1};
  assign d_ld   = {load_dcard3, load_dcard2, load_dcard1};
  assign lights = {player_win_light, dealer_win_light};

  always_comb begin
    card_ok   = rank_valid(new_card);
    any_load  = |{p_ld, d_ld};
    pslot_d   = pslot_q;
    dslot_d   = dslot_q;
    // An invalid rank is ignored entirely, so it cannot start a new hand either.
    if (card_ok) begin
      if (load_pcard1) begin
        pslot_d[1] = RANK_EMPTY;
        pslot_d[2] = RANK_EMPTY;
        dslot_d    = '0;
      end
      for (int i = 0; i < 3; i++) begin
        if (p_ld[i]) pslot_d[i] = new_card;
        if (d_ld[i]) dslot_d[i] = new_card;
      end
    end
    err_d = err_q | (any_load & ~card_ok);

    round_evt = (lights_prev_q == LIGHTS_NONE) && (lights != LIGHTS_NONE);
    p_wins_d  = p_wins_q;
    d_wins_d  = d_wins_q;
    ties_d    = ties_q;
    rounds_d  = rounds_q;
    if (round_evt) begin
      rounds_d = sat_inc(rounds_q);
      case (lights)
        LIGHTS_TIE:    ties_d   = sat_inc(ties_q);
        LIGHTS_PLAYER: p_wins_d = sat_inc(p_wins_q);
        LIGHTS_DEALER: d_wins_d = sat_inc(d_wins_q);
        default:       ;
      endcase
    end
  end

  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      pslot_q       <= '0;
      dslot_q       <= '0;
      err_q         <= 1'b0;
      lights_prev_q <= LIGHTS_NONE;
      p_wins_q      <= '0;
      d_wins_q      <= '0;
      ties_q        <= '0;
      rounds_q      <= '0;
    end else begin
      pslot_q       <= pslot_d;
      dslot_q       <= dslot_d;
      err_q         <= err_d;
      lights_prev_q <= lights;
      p_wins_q      <= p_wins_d;
      d_wins_q      <= d_wins_d;
      ties_q        <= ties_d;
      rounds_q      <= rounds_d;
    end
  end

  score_hand u_player (
    .card1_i (pslot_q[0]),
    .card2_i (pslot_q[1]),
    .card3_i (pslot_q[2]),
    .score_o (pscore)
  );

  score_hand u_dealer (
    .card1_i (dslot_q[0]),
    .card2_i (dslot_q[1]),
    .card3_i (dslot_q[2]),
    .score_o (dscore)
  );

  assign pcard1     = pslot_q[0];
  assign pcard2     = pslot_q[1];
  assign pcard3     = pslot_q[2];
  assign pcard3_out = pslot_q[2];
  assign dcard1     = dslot_q[0];
  assign dcard2     = dslot_q[1];
  assign dcard3     = dslot_q[2];
  assign card_err   = err_q;
  assign p_wins     = p_wins_q;
  assign d_wins     = d_wins_q;
  assign ties       = ties_q;
  assign rounds     = rounds_q;

endmodule

// File: tb/tb_card_datapath.sv
// Bench for card_datapath: directed scenarios plus random traffic against a hand/tally model.
module tb_card_datapath;
  import baccarat_pkg::*;

  logic  slow_clock = 1'b0;
  logic  resetb     = 1'b0;
  rank_t new_card   = '0;
  logic [5:0] ld    = '0;   // [0..2] pcard1..3, [3..5] dcard1..3
  logic  pwl = 1'b0, dwl = 1'b0;

  rank_t a_pc1, a_pc2, a_pc3, a_dc1, a_dc2, a_dc3, a_p3o;
  logic [3:0] a_ps, a_ds;
  logic [7:0] a_pw, a_dw, a_ti, a_rd;
  logic a_err;

  rank_t b_pc1, b_pc2, b_pc3, b_dc1, b_dc2, b_dc3, b_p3o;
  logic [3:0] b_ps, b_ds;
  logic [1:0] b_pw, b_dw, b_ti, b_rd;
  logic b_err;

  card_datapath #(.TALLY_W(8)) dut (
    .slow_clock(slow_clock), .resetb(resetb), .new_card(new_card),
    .load_pcard1(ld[0]), .load_pcard2(ld[1]), .load_pcard3(ld[2]),
    .load_dcard1(ld[3]), .load_dcard2(ld[4]), .load_dcard3(ld[5]),
    .player_win_light(pwl), .dealer_win_light(dwl),
    .pcard1(a_pc1), .pcard2(a_pc2), .pcard3(a_pc3),
    .dcard1(a_dc1), .dcard2(a_dc2), .dcard3(a_dc3), .pcard3_out(a_p3o),
    .pscore(a_ps), .dscore(a_ds),
    .p_wins(a_pw), .d_wins(a_dw), .ties(a_ti), .rounds(a_rd), .card_err(a_err)
  );

  card_datapath #(.TALLY_W(2)) dut_w2 (
    .slow_clock(slow_clock), .resetb(resetb), .new_card(new_card),
    .load_pcard1(ld[0]), .load_pcard2(ld[1]), .load_pcard3(ld[2]),
    .load_dcard1(ld[3]), .load_dcard2(ld[4]), .load_dcard3(ld[5]),
    .player_win_light(pwl), .dealer_win_light(dwl),
    .pcard1(b_pc1), .pcard2(b_pc2), .pcard3(b_pc3),
    .dcard1(b_dc1), .dcard2(b_dc2), .dcard3(b_dc3), .pcard3_out(b_p3o),
    .pscore(b_ps), .dscore(b_ds),
    .p_wins(b_pw), .d_wins(b_dw), .ties(b_ti), .rounds(b_rd), .card_err(b_err)
  );

  always #5 slow_clock = ~slow_clock;

  int n_tests = 0;
  int n_fail  = 0;

  int m_card[6];
  int m_err, m_prev, m_p, m_d, m_t, m_r;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int val(input int r);
    return (r >= 1 && r <= 9) ? r : 0;
  endfunction

  function automatic int sat(input int c, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  // Reference behaviour at one clock edge, from the current inputs.
  task automatic model_step();
    int lights;
    lights = {pwl, dwl};
    if (!resetb) begin
      for (int i = 0; i < 6; i++) m_card[i] = 0;
      m_err = 0; m_prev = 0; m_p = 0; m_d = 0; m_t = 0; m_r = 0;
      return;
    end
    if (ld != 6'b0) begin
      if (new_card >= 1 && new_card <= 13) begin
        if (ld[0]) begin
          m_card[1] = 0; m_card[2] = 0; m_card[3] = 0; m_card[4] = 0; m_card[5] = 0;
        end
        for (int i = 0; i < 6; i++) if (ld[i]) m_card[i] = int'(new_card);
      end else begin
        m_err = 1;
      end
    end
    if (m_prev == 0 && lights != 0) begin
      m_r++;
      if (lights == 3) m_t++;
      else if (lights == 2) m_p++;
      else m_d++;
    end
    m_prev = lights;
  endtask

  task automatic check_all();
    int ps, ds;
    ps = (val(m_card[0]) + val(m_card[1]) + val(m_card[2])) % 10;
    ds = (val(m_card[3]) + val(m_card[4]) + val(m_card[5])) % 10;
    chk("pcard1", a_pc1, m_card[0]);  chk("pcard2", a_pc2, m_card[1]);
    chk("pcard3", a_pc3, m_card[2]);  chk("pcard3_out", a_p3o, m_card[2]);
    chk("dcard1", a_dc1, m_card[3]);  chk("dcard2", a_dc2, m_card[4]);
    chk("dcard3", a_dc3, m_card[5]);
    chk("pscore", a_ps, ps);          chk("dscore", a_ds, ds);
    chk("card_err", a_err, m_err);
    chk("p_wins", a_pw, sat(m_p, 8)); chk("d_wins", a_dw, sat(m_d, 8));
    chk("ties", a_ti, sat(m_t, 8));   chk("rounds", a_rd, sat(m_r, 8));
    chk("w2_pcard1", b_pc1, m_card[0]); chk("w2_pcard2", b_pc2, m_card[1]);
    chk("w2_pcard3", b_pc3, m_card[2]); chk("w2_pcard3_out", b_p3o, m_card[2]);
    chk("w2_dcard1", b_dc1, m_card[3]); chk("w2_dcard2", b_dc2, m_card[4]);
    chk("w2_dcard3", b_dc3, m_card[5]);
    chk("w2_pscore", b_ps, ps);         chk("w2_dscore", b_ds, ds);
    chk("w2_card_err", b_err, m_err);
    chk("w2_p_wins", b_pw, sat(m_p, 2)); chk("w2_d_wins", b_dw, sat(m_d, 2));
    chk("w2_ties", b_ti, sat(m_t, 2));   chk("w2_rounds", b_rd, sat(m_r, 2));
  endtask

  task automatic tick();
    @(posedge slow_clock);
    model_step();
    #1;
    check_all();
  endtask

  task automatic load(input int slot, input int card);
    new_card = rank_t'(card);
    ld = 6'b0;
    ld[slot] = 1'b1;
    tick();
    ld = 6'b0;
  endtask

  task automatic lights_for(input logic [1:0] l, input int n);
    {pwl, dwl} = l;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    resetb = 1'b0;
    tick(); tick();
    chk("rst_pcard1", a_pc1, 0); chk("rst_rounds", a_rd, 0); chk("rst_err", a_err, 0);
    resetb = 1'b1;

    load(0, 7); load(1, 9);
    chk("d_pcard1", a_pc1, 7); chk("d_pcard2", a_pc2, 9);
    chk("d_pscore6", a_ps, 6); chk("d_dscore0", a_ds, 0); chk("d_err0", a_err, 0);

    load(0, 13); load(1, 12); load(2, 5);
    chk("d_p3out5", a_p3o, 5);
    load(3, 9); load(4, 9); load(5, 9);
    chk("d_pscore5", a_ps, 5); chk("d_dscore7", a_ds, 7);

    load(0, 3);
    chk("d_new_p1", a_pc1, 3); chk("d_new_p2", a_pc2, 0); chk("d_new_p3", a_pc3, 0);
    chk("d_new_d1", a_dc1, 0); chk("d_new_d2", a_dc2, 0); chk("d_new_d3", a_dc3, 0);
    chk("d_new_ps", a_ps, 3);  chk("d_new_ds", a_ds, 0);

    load(4, 6); load(4, 14);
    chk("d_bad_dc2", a_dc2, 6); chk("d_bad_err", a_err, 1);
    load(5, 2);
    chk("d_ok_dc3", a_dc3, 2);
    lights_for(2'b00, 3);
    chk("d_err_held", a_err, 1);

    ld = 6'h3F; new_card = 4'd8;
    tick(); ld = 6'b0;
    chk("d_all_p2", a_pc2, 8); chk("d_all_d1", a_dc1, 8);

    lights_for(2'b10, 5); lights_for(2'b00, 1); lights_for(2'b11, 1);
    lights_for(2'b00, 1); lights_for(2'b01, 1);
    chk("d_lt_p", a_pw, 1); chk("d_lt_t", a_ti, 1); chk("d_lt_d", a_dw, 1); chk("d_lt_r", a_rd, 3);

    {pwl, dwl} = 2'b00; resetb = 1'b0; tick(); resetb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      lights_for(2'b10, 2); lights_for(2'b00, 1);
    end
    chk("d_sat_pw", b_pw, 3); chk("d_sat_rd", b_rd, 3); chk("d_w8_pw", a_pw, 5);
    resetb = 1'b0; tick(); resetb = 1'b1;
    chk("d_rst_pw", b_pw, 0); chk("d_rst_rd", b_rd, 0); chk("d_rst_err", a_err, 0);

    {pwl, dwl} = 2'b10; resetb = 1'b0; tick();
    chk("d_rst_lit", a_rd, 0);
    resetb = 1'b1; tick();
    chk("d_lit_once", a_rd, 1);
    tick();
    chk("d_lit_hold", a_rd, 1);

    for (int n = 0; n < 3000; n++) begin
      resetb   = ($urandom_range(0, 199) != 0);
      new_card = rank_t'($urandom_range(0, 15));
      for (int i = 0; i < 6; i++) ld[i] = ($urandom_range(0, 3) == 0);
      if (ld[0] && !(new_card >= 1 && new_card <= 13)) new_card = rank_t'($urandom_range(1, 13));
      if ($urandom_range(0, 3) == 0) {pwl, dwl} = 2'($urandom_range(0, 3));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
